// File: rtl/alu_control_md.sv
// EX-stage ALU control: registered ALUOp/funct decode plus an iterative
// multiply/divide sequencer that owns the HI/LO registers.
module alu_control_md #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              InValid,
    input  logic [1:0]        ALUOp,
    input  logic [5:0]        FuncCode,
    input  logic [DATA_W-1:0] OpA,
    input  logic [DATA_W-1:0] OpB,
    input  logic              Flush,
    output logic [3:0]        ALUCtl,
    output logic              CtlValid,
    output logic              Illegal,
    output logic [DATA_W-1:0] HiLoOut,
    output logic              HiLoValid,
    output logic              Stall
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [2*DATA_W:0]     acc_q;
    logic [DATA_W-1:0]     opb_q;
    logic                  div_q, dz_q, neg_lo_q, neg_hi_q;
    logic [DATA_W-1:0]     hi_q, lo_q;
    logic [3:0]            alu_ctl_q;
    logic                  ctl_valid_q, illegal_q, hilo_valid_q;
    logic [DATA_W-1:0]     hilo_out_q;

    // Returns {illegal, ctl}.
    function automatic logic [4:0] decode(input logic [1:0] op, input logic [5:0] fn);
        logic [4:0] r;
        r = 5'b0_0000;
        case (op)
            2'b00: r = 5'd2;
            2'b01: r = 5'd6;
            2'b11: r = 5'd15;
            default: begin
                case (fn)
                    6'b100000, 6'b100001: r = 5'd2;
                    6'b100010, 6'b100011: r = 5'd6;
                    6'b100100, 6'b001100: r = 5'd0;
                    6'b100101, 6'b001101: r = 5'd1;
                    6'b101010, 6'b001010: r = 5'd7;
                    6'b000100: r = 5'd9;
                    6'b100111: r = 5'd3;
                    6'b100110, 6'b001110: r = 5'd4;
                    6'b001111: r = 5'd8;
                    6'b000110: r = 5'd11;
                    6'b000111: r = 5'd13;
                    6'b000000: r = 5'd5;
                    6'b000010: r = 5'd10;
                    6'b000011: r = 5'd12;
                    6'b001001: r = 5'd15;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011,
                    6'b010000, 6'b010001, 6'b010010, 6'b010011: r = 5'd0;
                    default: r = 5'b1_0000;
                endcase
            end
        endcase
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v, input logic sgn);
        logic signed [DATA_W-1:0] s;
        s = v;
        return (sgn && s < 0) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] apply_sign2(input logic [2*DATA_W-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    logic       is_md, is_mfmt, is_mf, is_mt, accept, start, op_signed, a_neg, b_neg, b_zero;
    logic [4:0] dec;

    // funct only carries meaning for R-type, so HI/LO ops are recognised only under ALUOp=10.
    assign is_md     = (ALUOp == 2'b10) && (FuncCode[5:2] == 4'b0110);
    assign is_mfmt   = (ALUOp == 2'b10) && (FuncCode[5:2] == 4'b0100);
    assign is_mf     = is_mfmt & ~FuncCode[0];
    assign is_mt     = is_mfmt & FuncCode[0];
    assign Stall     = InValid & (state_q != S_IDLE) & (is_md | is_mfmt);
    assign accept    = InValid & ~Stall & ~Flush;
    assign start     = accept & is_md;
    assign dec       = decode(ALUOp, FuncCode);
    assign op_signed = ~FuncCode[0];
    assign a_neg     = op_signed & OpA[DATA_W-1];
    assign b_neg     = op_signed & OpB[DATA_W-1];
    assign b_zero    = (OpB == '0);

    // One shift-add or restoring-subtract step on the {upper, lower} accumulator.
    logic [DATA_W:0]   mul_sum, div_shift, div_diff;
    logic              div_ok;
    logic [2*DATA_W:0] mul_next, div_next;

    assign mul_sum   = acc_q[2*DATA_W:DATA_W] + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next  = {mul_sum, acc_q[DATA_W-1:0]} >> 1;
    assign div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    assign div_ok    = div_shift >= {1'b0, opb_q};
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_next  = div_ok ? {div_diff, acc_q[DATA_W-2:0], 1'b1}
                              : {div_shift, acc_q[DATA_W-2:0], 1'b0};

    // With a zero divisor every step succeeds, leaving |A| as remainder; its
    // dividend-sign correction then restores HI = OpA.
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   fix_hi, fix_lo;

    assign prod   = apply_sign2(acc_q[2*DATA_W-1:0], neg_lo_q);
    assign fix_hi = div_q ? apply_sign(acc_q[2*DATA_W-1:DATA_W], neg_hi_q) : prod[2*DATA_W-1:DATA_W];
    assign fix_lo = div_q ? (dz_q ? '1 : apply_sign(acc_q[DATA_W-1:0], neg_lo_q)) : prod[DATA_W-1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (Flush) state_d = S_IDLE;
                     else if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            opb_q        <= '0;
            div_q        <= 1'b0;
            dz_q         <= 1'b0;
            neg_lo_q     <= 1'b0;
            neg_hi_q     <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
            alu_ctl_q    <= '0;
            ctl_valid_q  <= 1'b0;
            illegal_q    <= 1'b0;
            hilo_valid_q <= 1'b0;
            hilo_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            ctl_valid_q  <= accept;
            illegal_q    <= accept & dec[4];
            hilo_valid_q <= accept & is_mf;
            if (accept) alu_ctl_q <= dec[3:0];
            if (accept && is_mf) hilo_out_q <= FuncCode[1] ? lo_q : hi_q;
            if (accept && is_mt) begin
                if (FuncCode[1]) lo_q <= OpA;
                else             hi_q <= OpA;
            end
            if (start) begin
                acc_q    <= {{(DATA_W+1){1'b0}}, magnitude(OpA, op_signed)};
                opb_q    <= magnitude(OpB, op_signed);
                cnt_q    <= CNT_W'(DATA_W);
                div_q    <= FuncCode[1];
                dz_q     <= FuncCode[1] & b_zero;
                neg_lo_q <= (a_neg ^ b_neg) & ~(FuncCode[1] & b_zero);
                neg_hi_q <= a_neg;
            end else if (state_q == S_RUN && !Flush) begin
                acc_q <= div_q ? div_next : mul_next;
                cnt_q <= cnt_q - 1'b1;
            end
            if (state_q == S_FIX && !Flush) begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end
        end
    end

    assign ALUCtl    = alu_ctl_q;
    assign CtlValid  = ctl_valid_q;
    assign Illegal   = illegal_q;
    assign HiLoOut   = hilo_out_q;
    assign HiLoValid = hilo_valid_q;

endmodule

// File: doc/alu_control_md.md
# alu_control_md

Registered ALU control unit with an integrated iterative multiply/divide sequencer for the EX stage of the MIPS pipeline. It decodes ALUOp/FuncCode into the 4-bit ALU operation code one cycle ahead of use. It adds MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO support through HI/LO registers, and raises a pipeline stall while a multi-cycle operation is in flight.

## Interface
Parameters:
- DATA_W, 32, operand and HI/LO width (≥ 8).
- CNT_W, $clog2(DATA_W)+1, iteration counter width.

Ports:
- clk  in  1  rising-edge clock. One clock only.
- rst_n  in  1  synchronous, active-low reset.
- InValid  in  1  instruction present in EX this cycle.
- ALUOp  in  2  00 = load/store, 01 = branch, 10 = R-type, 11 = JAL.
- FuncCode  in  6  instruction funct field.
- OpA, OpB  in  DATA_W  rs, rt values.
- Flush  in  1  kill current instruction and any in-flight mul/div.
- ALUCtl  out  4  registered ALU op code.
- CtlValid  out  1  ALUCtl is valid.
- Illegal  out  1  registered, unknown funct when ALUOp=10.
- HiLoOut  out  DATA_W  registered MFHI/MFLO result.
- HiLoValid  out  1  HiLoOut valid, 1-cycle pulse.
- Stall  out  1  combinational, hold EX and upstream.

## Operation
- ALU op encoding: AND/ANDI 0, OR/ORI 1, ADD/ADDI/ADDU 2, NOR 3, XOR/XORI 4, SLL 5, SUB/SUBU 6, SLT/SLTI 7, LUI 8, SLLV 9, SRL 10, SRLV 11, SRA 12, SRAV 13, JAL/JALR 15.
- ALUOp mapping: 00→2, 01→6, 11→15.
- ALUOp 10 funct mapping:
  - 100000→2, 100010→6, 100100/001100→0, 100101/001101→1, 101010/001010→7.
  - 000100→9, 100111→3, 100110/001110→4, 001111→8, 000110→11, 000111→13.
  - 000000→5, 000010→10, 000011→12, 100001→2, 100011→6, 001001→15.
- New funct codes: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011. These drive ALUCtl=0.
- Any other funct: ALUCtl=0, Illegal=1.
- The sequencer FSM has three states: IDLE, RUN, FIX.
  - IDLE→RUN: accepted MULT/MULTU/DIV/DIVU. Latch |OpA| and |OpB| (raw values for the unsigned ops), result signs, and the divide-by-zero flag. Counter = DATA_W.
  - RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle. Counter decrements. RUN→FIX when the counter reaches 1.
  - FIX→IDLE: apply sign correction and write HI/LO.
- MULT/MULTU: {HI,LO} = full 2·DATA_W-bit product, signed or unsigned.
- DIV/DIVU: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- DIV with MIN / -1: LO = MIN, HI = 0.
- Divide by zero: LO = all ones, HI = OpA. Normal latency still applies.
- MTHI/MTLO write HI/LO at the end of the accept cycle.
- MFHI/MFLO drive HiLoOut/HiLoValid on the next cycle.
- An instruction is accepted when InValid=1, Stall=0 and Flush=0.

## Timing
- Reset values: ALUCtl=0, CtlValid=0, Illegal=0, HiLoOut=0, HiLoValid=0, Stall=0, HI=LO=0, state IDLE.
- Decode latency is 1 cycle. CtlValid mirrors the accepted InValid.
- Mul/div latency: accepted at cycle 0; RUN covers cycles 1..DATA_W; FIX is cycle DATA_W+1. HI/LO are visible from cycle DATA_W+2.
- Stall = InValid & (state≠IDLE) & (funct is any mul/div/MF/MT op).
  - Non-HI/LO instructions proceed during RUN/FIX without stall.
  - A stalled instruction is accepted in the first cycle the state is IDLE.
- Flush has priority over InValid.
  - Flush aborts RUN/FIX and returns to IDLE on the next edge. HI/LO are unchanged.
  - Flush clears CtlValid, HiLoValid and Illegal on the next edge.
- rst_n=0 mid-operation: every output and register returns to its reset value on that edge. No partial HI/LO write.

## Test plan
- ALUOp=10, FuncCode=100000 → ALUCtl=2, CtlValid=1 one cycle later. FuncCode=111111 → ALUCtl=0, Illegal=1.
- MULT OpA=-3, OpB=5 (DATA_W=32) → Stall on dependent ops for 33 cycles; then HI=FFFFFFFF, LO=FFFFFFF1.
- DIVU 100/7 → LO=14, HI=2. DIV -7/2 → LO=FFFFFFFD, HI=FFFFFFFF. DIV 5/0 → LO=FFFFFFFF, HI=5.
- MFLO issued 1 cycle after MULT 6×7 → Stall held until IDLE; HiLoOut=42 with a 1-cycle HiLoValid pulse. An ADD in between is not stalled.
- Flush at cycle 10 of a DIV → IDLE next cycle, HI/LO retain the prior MTHI/MTLO values (0x11/0x22).
- rst_n low at cycle 5 of MULT → all outputs 0, Stall=0, HI=LO=0 after the edge.
